// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Steps the datapath through a conditional branch: read the condition
//   register (RD), move PC into Y (ADDR), add the immediate offset (CALC),
//   then load PC from Zlow only when the branch condition held (COMMIT).
//
// Parameters
//   BR_OPCODE  branch opcode compared against ir[31:27]
//   C2_LSB     LSB of the 2-bit condition field ir[C2_LSB+1:C2_LSB]
//
// Ports
//   clock        single clock, rising-edge
//   reset        synchronous active-high reset
//   start        one-cycle request to run the branch held in ir
//   ir           instruction word, sampled only when start is accepted
//   bus_mux_out  datapath bus, evaluated at the end of RD
//   gra, r_out, con_in                RD strobes
//   pc_out, y_in                      ADDR strobes
//   c_out, alu_add, z_in              CALC strobes
//   zlow_out, pc_in                   COMMIT strobes, only for a taken branch
//   busy         high in every state except IDLE
//   done         one-cycle pulse in COMMIT
//   taken        registered branch condition, valid ADDR..COMMIT and held
//   err          registered one-cycle pulse for a start with a wrong opcode
//
// Optional feature (macro BRANCH_STATS_EN)
//   taken_count, not_taken_count  16-bit wrapping counters of completed
//   branches, cleared by reset. Absent entirely when the macro is undefined.
//
// States
//   state  | meaning
//   IDLE   | waiting for start with a matching opcode
//   RD     | condition register on the bus, CON flag evaluated
//   ADDR   | PC driven onto the bus, loaded into Y
//   CALC   | immediate added to Y, result captured in Z
//   COMMIT | PC loaded from Zlow if taken; done pulse

module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE = 5'b10011,
  parameter int         C2_LSB    = 19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] bus_mux_out,
  output logic        gra,
  output logic        r_out,
  output logic        con_in,
  output logic        pc_out,
  output logic        y_in,
  output logic        c_out,
  output logic        alu_add,
  output logic        z_in,
  output logic        zlow_out,
  output logic        pc_in,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        err
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_count,
  output logic [15:0] not_taken_count
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    ADDR   = 3'd2,
    CALC   = 3'd3,
    COMMIT = 3'd4
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [1:0]  c2;
  logic        opMatch;
  logic        accept;
  logic        condMet;
  logic        unusedIrBits;

  assign opMatch = (ir[31:27] == BR_OPCODE);
  assign accept  = (state == IDLE) && start && opMatch;

  // Only the opcode and condition fields of ir matter here.
  assign unusedIrBits = ^ir;

  always_comb begin
    condMet = 1'b0;
    case (c2)
      2'b00: condMet = ~|bus_mux_out;
      2'b01: condMet = |bus_mux_out;
      2'b10: condMet = ~bus_mux_out[31];
      2'b11: condMet = bus_mux_out[31];
      default: condMet = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      c2    <= 2'b00;
      taken <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nextState;
      // A start is only judged in IDLE; while busy it is silently dropped.
      err   <= (state == IDLE) && start && !opMatch;
      if (accept) begin
        c2    <= ir[C2_LSB +: 2];
        taken <= 1'b0;
      end
      // RD always exits to ADDR, so this is the single bus sample point.
      if (state == RD) begin
        taken <= condMet;
      end
    end
  end

  always_comb begin
    nextState = state;
    gra       = 1'b0;
    r_out     = 1'b0;
    con_in    = 1'b0;
    pc_out    = 1'b0;
    y_in      = 1'b0;
    c_out     = 1'b0;
    alu_add   = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    pc_in     = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = RD;
        end
      end
      RD: begin
        gra       = 1'b1;
        r_out     = 1'b1;
        con_in    = 1'b1;
        nextState = ADDR;
      end
      ADDR: begin
        pc_out    = 1'b1;
        y_in      = 1'b1;
        nextState = CALC;
      end
      CALC: begin
        c_out     = 1'b1;
        alu_add   = 1'b1;
        z_in      = 1'b1;
        nextState = COMMIT;
      end
      COMMIT: begin
        done      = 1'b1;
        zlow_out  = taken;
        pc_in     = taken;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      taken_count     <= 16'd0;
      not_taken_count <= 16'd0;
    end else if (state == COMMIT) begin
      if (taken) begin
        taken_count <= taken_count + 16'd1;
      end else begin
        not_taken_count <= not_taken_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed branches for each
// condition code, wrong-opcode and busy-start rejection, reset during a
// sequence, and a run of randomized branches against a reference model.

module tb_branch_sequencer;

  localparam logic [4:0] BR = 5'b10011;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] ir;
  logic [31:0] bus_mux_out;
  logic        gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in;
  logic        zlow_out, pc_in, busy, done, taken, err;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count, not_taken_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state: last committed condition result and branch tallies.
  bit lastTaken = 1'b0;
  int refTakenCnt = 0;
  int refNotTakenCnt = 0;

  branch_sequencer dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .ir(ir),
    .bus_mux_out(bus_mux_out),
    .gra(gra),
    .r_out(r_out),
    .con_in(con_in),
    .pc_out(pc_out),
    .y_in(y_in),
    .c_out(c_out),
    .alu_add(alu_add),
    .z_in(z_in),
    .zlow_out(zlow_out),
    .pc_in(pc_in),
    .busy(busy),
    .done(done),
    .taken(taken),
    .err(err)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count(taken_count),
    .not_taken_count(not_taken_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [12:0] obsVec;
  assign obsVec = {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
                   zlow_out, pc_in, done, busy, err};

  // Branch condition from its meaning: equal zero, nonzero, non-negative, negative.
  function automatic bit refCond(input logic [1:0] c2v, input logic [31:0] v);
    case (c2v)
      2'd0: return v == 32'd0;
      2'd1: return v != 32'd0;
      2'd2: return $signed(v) >= 0;
      default: return $signed(v) < 0;
    endcase
  endfunction

  // Expected strobes for phase 0=IDLE 1=RD 2=ADDR 3=CALC 4=COMMIT.
  function automatic logic [12:0] expVec(input int phase, input bit tk, input bit e);
    logic [12:0] v;
    v = 13'd0;
    case (phase)
      1: v[12:10] = 3'b111;
      2: v[9:8]   = 2'b11;
      3: v[7:5]   = 3'b111;
      4: begin
        v[4] = tk;
        v[3] = tk;
        v[2] = 1'b1;
      end
      default: v = 13'd0;
    endcase
    v[1] = (phase != 0);
    v[0] = e;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkStats(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, "_tcnt"}, {16'd0, taken_count}, refTakenCnt % 65536);
    check({tag, "_ntcnt"}, {16'd0, not_taken_count}, refNotTakenCnt % 65536);
`else
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
`endif
  endtask

  // One complete branch; optionally pokes start during ADDR and COMMIT.
  task automatic runBranch(input logic [1:0] c2v, input logic [31:0] busv,
                           input bit pokeAddr, input bit pokeCommit);
    logic [31:0] r;
    bit tk;
    tk = refCond(c2v, busv);
    r = $urandom();
    ir = {BR, r[26:0]};
    ir[20:19] = c2v;
    start = 1'b1;
    bus_mux_out = $urandom();
    step();
    start = 1'b0;
    ir = $urandom();
    check("rd_strobes", {19'd0, obsVec}, {19'd0, expVec(1, 1'b0, 1'b0)});
    bus_mux_out = busv;
    step();
    check("addr_strobes", {19'd0, obsVec}, {19'd0, expVec(2, 1'b0, 1'b0)});
    check("addr_taken", {31'd0, taken}, {31'd0, tk});
    bus_mux_out = ~busv;
    if (pokeAddr) begin
      r = $urandom();
      ir = {5'b00011, r[26:0]};
      start = 1'b1;
    end
    step();
    start = 1'b0;
    check("calc_strobes", {19'd0, obsVec}, {19'd0, expVec(3, 1'b0, 1'b0)});
    check("calc_taken", {31'd0, taken}, {31'd0, tk});
    bus_mux_out = $urandom();
    step();
    check("commit_strobes", {19'd0, obsVec}, {19'd0, expVec(4, tk, 1'b0)});
    check("commit_taken", {31'd0, taken}, {31'd0, tk});
    if (pokeCommit) begin
      r = $urandom();
      ir = {BR, r[26:0]};
      start = 1'b1;
    end
    step();
    start = 1'b0;
    lastTaken = tk;
    if (tk) refTakenCnt++;
    else refNotTakenCnt++;
    check("idle_strobes", {19'd0, obsVec}, {19'd0, expVec(0, 1'b0, 1'b0)});
    check("idle_taken_held", {31'd0, taken}, {31'd0, lastTaken});
    checkStats("post_branch");
  endtask

  task automatic badOpcode(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom();
    ir = {op, r[26:0]};
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_pulse", {19'd0, obsVec}, {19'd0, expVec(0, 1'b0, 1'b1)});
    check("err_taken_held", {31'd0, taken}, {31'd0, lastTaken});
    step();
    check("err_cleared", {19'd0, obsVec}, {19'd0, expVec(0, 1'b0, 1'b0)});
  endtask

  initial begin
    logic [31:0] pick;
    logic [4:0] op;
    reset = 1'b1;
    start = 1'b1;
    ir = {BR, 27'd0};
    bus_mux_out = 32'd0;
    step();
    step();
    check("reset_strobes", {19'd0, obsVec}, 32'd0);
    check("reset_taken", {31'd0, taken}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    step();
    check("post_reset_idle", {19'd0, obsVec}, 32'd0);
    checkStats("post_reset");

    // Directed condition cases.
    runBranch(2'b00, 32'd0, 1'b0, 1'b0);
    runBranch(2'b01, 32'd0, 1'b0, 1'b0);
    runBranch(2'b10, 32'h8000_0000, 1'b0, 1'b0);
    runBranch(2'b11, 32'h8000_0000, 1'b0, 1'b0);
    runBranch(2'b10, 32'd0, 1'b0, 1'b0);

    // Rejections: wrong opcode in IDLE, start while busy.
    badOpcode(5'b00011);
    runBranch(2'b01, 32'h0000_0100, 1'b1, 1'b1);

    // Reset in the middle of a sequence (during CALC).
    ir = {BR, 27'd0};
    start = 1'b1;
    step();
    start = 1'b0;
    bus_mux_out = 32'd0;
    step();
    step();
    check("pre_abort_calc", {19'd0, obsVec}, {19'd0, expVec(3, 1'b0, 1'b0)});
    reset = 1'b1;
    step();
    reset = 1'b0;
    lastTaken = 1'b0;
    refTakenCnt = 0;
    refNotTakenCnt = 0;
    check("abort_strobes", {19'd0, obsVec}, 32'd0);
    check("abort_taken", {31'd0, taken}, 32'd0);
    checkStats("abort");
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_no_done", {31'd0, done}, 32'd0);
    end

    // Three taken branches after the abort.
    for (int i = 0; i < 3; i++) begin
      runBranch(2'b00, 32'd0, 1'b0, 1'b0);
    end
`ifdef BRANCH_STATS_EN
    check("three_taken", {16'd0, taken_count}, 32'd3);
`endif

    // Randomized branches, bad opcodes and busy pokes.
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: bus_mux_out = 32'd0;
        1: bus_mux_out = 32'h8000_0000;
        2: bus_mux_out = 32'h7FFF_FFFF;
        3: bus_mux_out = 32'd1;
        default: bus_mux_out = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) begin
        op = 5'($urandom_range(0, 31));
        if (op == BR) op = 5'b00000;
        badOpcode(op);
      end
      runBranch(2'($urandom_range(0, 3)), bus_mux_out,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        step();
        check("gap_idle", {19'd0, obsVec}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter BR_OPCODE, default 5'b10011, the branch opcode matched against ir[31:27].
REQ-002 Parameter C2_LSB, default 19, the LSB of the 2-bit condition field ir[C2_LSB+1:C2_LSB].
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to execute the branch held in ir.
REQ-006 ir  input  32  instruction register contents, sampled only on an accepted start.
REQ-007 bus_mux_out  input  32  datapath bus value, evaluated during the RD state.
REQ-008 gra, r_out, con_in  output  1 each  register-select-A, register-out and CON-capture strobes.
REQ-009 pc_out, y_in  output  1 each  PC-to-bus and Y-load strobes.
REQ-010 c_out, alu_add, z_in  output  1 each  immediate-out, ALU ADD select and Z-load strobes.
REQ-011 zlow_out, pc_in  output  1 each  Zlow-to-bus and PC-load strobes (taken branch only).
REQ-012 busy  output  1  high in every non-IDLE state.
REQ-013 done  output  1  one-cycle pulse in the COMMIT state.
REQ-014 taken  output  1  registered CON result, valid from ADDR through COMMIT and held until the next accepted start.
REQ-015 err  output  1  one-cycle pulse, registered, when start arrives in IDLE with ir[31:27] != BR_OPCODE.

Function
REQ-016 FSM states: IDLE, RD, ADDR, CALC, COMMIT; all strobe outputs are decoded from the state only (Moore).
REQ-017 IDLE -> RD on start=1 with a matching opcode; latch c2 = ir[C2_LSB+1:C2_LSB] on that edge.
REQ-018 start while busy=1 is ignored: no latch, no err, no state change.
REQ-019 RD: gra=r_out=con_in=1; on exit latch taken = (c2==00: ~|bus_mux_out; 01: |bus_mux_out; 10: ~bus_mux_out[31]; 11: bus_mux_out[31]).
REQ-020 ADDR: pc_out=y_in=1.
REQ-021 CALC: c_out=alu_add=z_in=1.
REQ-022 COMMIT: done=1; zlow_out=pc_in=taken; next state IDLE unconditionally.
REQ-023 Latency: start accepted at edge N; done is high in cycle N+4; a new start is accepted at edge N+5 or later.
REQ-024 A start asserted in the COMMIT cycle is ignored, because busy=1.
REQ-025 All strobes other than those listed for the current state are 0; no two states share a strobe.
REQ-026 bus_mux_out is sampled only at the RD exit edge; its changes in other states have no effect.

Reset
REQ-027 reset=1 at a rising edge forces IDLE, c2=00, taken=0 and err=0 on that edge; all strobes and done read 0 in the following cycle.
REQ-028 reset takes priority over start and over any in-flight sequence; an aborted sequence produces no done pulse.

Configuration
REQ-029 Macro BRANCH_STATS_EN, when defined, adds outputs taken_count[15:0] and not_taken_count[15:0].
REQ-030 With BRANCH_STATS_EN defined, the matching counter increments in COMMIT, wraps from 16'hFFFF to 0, and clears on reset.
REQ-031 Without BRANCH_STATS_EN, neither port nor any counter logic exists, and all other behaviour is identical.

Verification
REQ-032 Reset, then start with ir[31:27]=10011 and c2=00, bus_mux_out=0 in RD -> strobes in order RD, ADDR, CALC, COMMIT; taken=1; zlow_out=pc_in=1 in COMMIT; done at N+4.
REQ-033 c2=01, bus_mux_out=0 -> taken=0; COMMIT shows done=1 and zlow_out=pc_in=0.
REQ-034 c2=10 with bus_mux_out=32'h8000_0000 -> taken=0; c2=11 with the same value -> taken=1; c2=10 with 0 -> taken=1.
REQ-035 start with ir[31:27]=00011 in IDLE -> err pulses for 1 cycle, busy stays 0; start pulsed during ADDR -> ignored, single done.
REQ-036 reset asserted during CALC -> IDLE next cycle, no done, taken=0; with BRANCH_STATS_EN, counters read 0 and taken_count reaches 3 after three taken branches.
